// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Two-source round-robin arbiter. It drives the select of a 2:1 mux and
//   registers the chosen word into a single-entry output stage.
//
// Ports
//   clk, rst_n           : clock; synchronous active-low reset
//   I0, I0_valid, I0_ready : source 0 data / valid / ready (ready is combinational)
//   I1, I1_valid, I1_ready : source 1 data / valid / ready (ready is combinational)
//   A                    : registered select of the last accepted source
//   Q, Q_valid, Q_ready  : registered output data / valid / downstream ready
//
// Handshake: a word moves across an interface on a rising edge where its
//   valid and ready are both 1. Valid never depends on ready. Q and Q_valid
//   hold steady while Q_valid=1 and Q_ready=0. The input readies are
//   combinational from the valids, Q_ready and the stage state. There is no
//   path from input data to Q other than through the register.

module rr_mux_arbiter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I0,
    input  logic             I0_valid,
    output logic             I0_ready,
    input  logic [WIDTH-1:0] I1,
    input  logic             I1_valid,
    output logic             I1_ready,
    output logic             A,
    output logic [WIDTH-1:0] Q,
    output logic             Q_valid,
    input  logic             Q_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    logic   last;        // source granted most recently; the other wins a tie
    logic   can_accept;
    logic   grant;       // winning source when grant_en is set
    logic   grant_en;

    // Gating with rst_n keeps both readies low while reset is held, so no
    // source believes it was accepted on a reset edge.
    assign can_accept = rst_n && ((state == EMPTY) || (Q_valid && Q_ready));

    always_comb begin
        grant = I1_valid;
        if (I0_valid && I1_valid) begin
            grant = ~last;
        end
        grant_en = can_accept && (I0_valid || I1_valid);
    end

    assign I0_ready = grant_en && !grant;
    assign I1_ready = grant_en && grant;
    assign Q_valid  = (state == FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            Q     <= '0;
            A     <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (grant_en) begin
                        Q     <= grant ? I1 : I0;
                        A     <= grant;
                        last  <= grant;
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (grant_en) begin
                        // Drain and refill on the same edge.
                        Q     <= grant ? I1 : I0;
                        A     <= grant;
                        last  <= grant;
                        state <= FULL;
                    end else if (Q_ready) begin
                        // Q and A keep their last values once drained.
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Testbench for rr_mux_arbiter (WIDTH = 1).
//   A transaction-level model (one-deep holding queue plus a "favoured
//   source" pointer) is checked against the DUT on every falling edge.
//   Directed phases also pin literal values computed by hand.
module tb_rr_mux_arbiter;

    localparam int W = 1;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] i0, i1, q;
    logic         i0_valid, i1_valid, i0_ready, i1_ready;
    logic         a, q_valid, q_ready;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .I0       (i0),
        .I0_valid (i0_valid),
        .I0_ready (i0_ready),
        .I1       (i1),
        .I1_valid (i1_valid),
        .I1_ready (i1_ready),
        .A        (a),
        .Q        (q),
        .Q_valid  (q_valid),
        .Q_ready  (q_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rn, input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1, input logic qr);
        rst_n    = rn;
        i0_valid = v0;
        i0       = d0;
        i1_valid = v1;
        i1       = d1;
        q_ready  = qr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [W-1:0] eq, input logic ea);
        chk({tag, ".q_valid"}, 32'(q_valid), 32'(ev));
        chk({tag, ".q"},       32'(q),       32'(eq));
        chk({tag, ".a"},       32'(a),       32'(ea));
    endtask

    task automatic chk_rdy(input string tag, input logic e0, input logic e1);
        chk({tag, ".i0_ready"}, 32'(i0_ready), 32'(e0));
        chk({tag, ".i1_ready"}, 32'(i1_ready), 32'(e1));
    endtask

    // ---------------- scoreboard / model ----------------
    // exp_q holds the word sitting in the output stage (at most one).
    logic [W-1:0] exp_q[$];
    logic [W-1:0] shown_q;
    logic         shown_a;
    int           favour;     // source that wins when both request
    bit           model_on = 0;

    always @(negedge clk) begin
        int           winner;
        bit           slot_free;
        logic [W-1:0] word;
        if (!rst_n) begin
            if (model_on) chk_rdy("model_rst", 1'b0, 1'b0);
            exp_q.delete();
            shown_q  = '0;
            shown_a  = 1'b0;
            favour   = 0;
            model_on = 1;
        end else if (model_on) begin
            chk("model.q_valid", 32'(q_valid), 32'(exp_q.size() != 0));
            chk("model.q",       32'(q),       32'(shown_q));
            chk("model.a",       32'(a),       32'(shown_a));
            slot_free = (exp_q.size() == 0) || q_ready;
            winner = -1;
            if (slot_free) begin
                if (i0_valid && i1_valid) winner = favour;
                else if (i0_valid)        winner = 0;
                else if (i1_valid)        winner = 1;
            end
            chk("model.i0_ready", 32'(i0_ready), 32'(winner == 0));
            chk("model.i1_ready", 32'(i1_ready), 32'(winner == 1));
            if (slot_free && exp_q.size() != 0) void'(exp_q.pop_front());
            if (winner >= 0) begin
                word = (winner == 0) ? i0 : i1;
                exp_q.push_back(word);
                shown_q = word;
                shown_a = (winner == 1);
                favour  = 1 - winner;
            end
        end
    end

    // ---------------- directed vectors for the model-only phase ----------------
    typedef struct packed {
        logic rn, v0, d0, v1, d1, qr;
    } vec_t;

    vec_t vecs[16] = '{
        '{1,1,1,1,0,1}, '{1,1,1,1,0,0}, '{1,1,0,1,1,0}, '{1,1,0,1,1,1},
        '{1,0,0,1,1,1}, '{1,0,0,1,0,1}, '{1,1,1,0,0,1}, '{1,1,0,1,1,1},
        '{1,0,0,0,0,0}, '{1,0,0,0,0,1}, '{1,0,0,0,0,1}, '{1,1,1,1,1,0},
        '{0,1,1,1,1,0}, '{1,1,1,1,0,1}, '{1,1,0,1,1,1}, '{1,0,0,0,0,1}
    };

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

        // Reset with both valids high: everything low throughout.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_rdy("rst_pre", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out("rst", 1'b0, 1'b0, 1'b0);
            chk_rdy("rst", 1'b0, 1'b0);
        end

        // Single source I1.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_rdy("single0", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("single", 1'b1, 1'b1, 1'b1);
            chk_rdy("single", 1'b0, 1'b1);
        end

        // Contention from reset: I0 wins first, then strict alternation.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk_rdy("contend", 1'((i % 2) == 0), 1'((i % 2) == 1));
            tick();
            chk_out("contend", 1'b1, 1'((i % 2) == 1), 1'((i % 2) == 1));
        end

        // Backpressure: accept I0=1, stall 3 cycles with I1 waiting.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_rdy("bp_load", 1'b1, 1'b0);
        tick();
        chk_out("bp_load", 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_rdy("bp_stall", 1'b0, 1'b0);
            tick();
            chk_out("bp_stall", 1'b1, 1'b1, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_rdy("bp_release", 1'b0, 1'b1);
        tick();
        chk_out("bp_release", 1'b1, 1'b0, 1'b1);

        // Drain: one transfer of I0=1, then nothing; Q/A retained.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_rdy("drain_load", 1'b1, 1'b0);
        tick();
        chk_out("drain_load", 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_rdy("drain", 1'b0, 1'b0);
        tick();
        chk_out("drain", 1'b0, 1'b1, 1'b0);

        // Reset mid-operation: pointer sits at I0 before reset, so without
        // the pointer reset I1 would win the next tie.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("mid_load", 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_rdy("mid_rst", 1'b0, 1'b0);
        tick();
        chk_out("mid_rst", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk_rdy("mid_after", 1'b1, 1'b0);
        tick();
        chk_out("mid_after", 1'b1, 1'b1, 1'b0);

        // Mixed vectors, checked by the model only.
        foreach (vecs[k]) begin
            drive(vecs[k].rn, vecs[k].v0, vecs[k].d0, vecs[k].v1, vecs[k].d1, vecs[k].qr);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Two-source round-robin arbiter that generates the select for a 2:1 multiplexer and registers the selected data into a single-entry output stage with valid/ready handshaking. It sits directly upstream of the `multiplexer_circuit` datapath. It decides each cycle which of `I0`/`I1` is forwarded and drives the select `A`. The registered `Q`/`Q_valid` pair feeds the next consumer.

## Interface
- `WIDTH`, default 1: data width of `I0`, `I1` and `Q`.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on rising edge of `clk`.
- `I0` input WIDTH: source 0 data.
- `I0_valid` input 1: source 0 has data.
- `I0_ready` output 1: source 0 data accepted this cycle (combinational).
- `I1` input WIDTH: source 1 data.
- `I1_valid` input 1: source 1 has data.
- `I1_ready` output 1: source 1 data accepted this cycle (combinational).
- `A` output 1: registered select of the last accepted source (0 = `I0`, 1 = `I1`).
- `Q` output WIDTH: registered selected data.
- `Q_valid` output 1: `Q` holds valid data.
- `Q_ready` input 1: downstream accepts `Q` this cycle.

## Operation
- Reset values when `rst_n` = 0 at the edge:
  - `Q` = 0, `Q_valid` = 0, `A` = 0.
  - State = EMPTY.
  - Priority pointer `last` = 1, so `I0` wins the first contention.
- FSM has two states:
  - **EMPTY**: `Q_valid` = 0.
  - **FULL**: `Q_valid` = 1.
- `can_accept` = (state == EMPTY) or (`Q_valid` and `Q_ready`).
- Grant rules, evaluated only when `can_accept`:
  - Only `I0_valid` → grant 0.
  - Only `I1_valid` → grant 1.
  - Both valid → grant the source ≠ `last`.
  - Neither valid → no grant.
- `Ix_ready` = `can_accept` and grant == x. At most one ready is high per cycle, and ready never asserts without the matching valid.
- On a grant at the edge:
  - `Q` ← selected data.
  - `A` ← grant.
  - `last` ← grant.
  - State → FULL.
- If FULL, `Q_ready` = 1 and no grant: state → EMPTY. `Q` and `A` hold their values; `Q_valid` drops.
- If FULL and `Q_ready` = 0: `Q`, `A` and state hold. Both readies are 0.
- `last` updates only on a grant. A single requester does not disturb fairness bookkeeping beyond recording its grant.
- Data is transferred unmodified. No width conversion.

## Timing
- Latency is 1 cycle: data accepted at edge N appears on `Q` with `Q_valid` = 1 after edge N.
- Throughput is 1 transfer per cycle when `Q_ready` is held high (simultaneous drain and refill).
- Readies are combinational from `Ix_valid`, `Q_ready` and state. There is no combinational path from `Ix` data to `Q`.
- `Q_valid` and `Q` are stable while `Q_valid` = 1 and `Q_ready` = 0 (AXI-style hold).
- Inputs are sampled only at the rising edge. Changes to `Ix_valid`/`Ix` between edges have no effect other than on the combinational readies.
- Reset mid-transfer: a held `Q` is discarded and `Q_valid` = 0 on the next cycle. The pointer returns to `last` = 1. Readies are 0 while `rst_n` = 0.
- Both valid with continuous `Q_ready` = 1 → grants strictly alternate 0,1,0,1,… starting from the source ≠ `last`.

## Test plan
- **Reset**: hold `rst_n` = 0 for 2 cycles with both valids = 1, WIDTH = 1.
  - `Q` = 0, `Q_valid` = 0, `A` = 0, `I0_ready` = `I1_ready` = 0 throughout.
- **Single source**: `I1_valid` = 1, `I1` = 1, `I0_valid` = 0, `Q_ready` = 1.
  - `I1_ready` = 1 every cycle.
  - One cycle later: `Q` = 1, `A` = 1, `Q_valid` = 1, sustained.
- **Contention**: both valid, `I0` = 0, `I1` = 1, `Q_ready` = 1 from reset.
  - `A` sequence = 0,1,0,1 on `Q` cycles 1–4.
  - `Q` sequence = 0,1,0,1.
  - Exactly one ready high per cycle.
- **Backpressure**:
  - Accept `I0` = 1, then drop `Q_ready` = 0 for 3 cycles with `I1_valid` = 1, `I1` = 0.
  - During the stall: `Q` = 1, `A` = 0, `Q_valid` = 1 held, and `I1_ready` = 0.
  - On raising `Q_ready`: `I1_ready` = 1 that cycle, then `Q` = 0, `A` = 1 the next cycle.
- **Drain to empty**: single transfer, then no valids with `Q_ready` = 1.
  - `Q_valid` drops 1 cycle after the transfer completes.
  - `Q` and `A` retain their last values.
- **Reset mid-operation**: assert `rst_n` = 0 while FULL with `Q_ready` = 0.
  - Next cycle: `Q_valid` = 0, `Q` = 0, `A` = 0.
  - After release with both valid: the first grant goes to `I0`.
